sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock, synchronous first-in first-out buffer, 2**ADDR_WIDTH entries of DATA_WIDTH bits.
- Decouples a producer and a consumer that share one clock.
- Provides registered read data and empty/full status.
- Overflowing writes and underflowing reads are ignored safely.

Parameters:
- ADDR_WIDTH, 5, log2 of depth (depth = 32).
- DATA_WIDTH, 8, width of each data word.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_WIDTH  write data.
- Wr_enable  input  1  write request.
- Read_enable  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- empty_flag  output  1  high when FIFO holds 0 entries.
- full_flag  output  1  high when FIFO holds 2**ADDR_WIDTH entries.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1 at clk edge) has priority over all else:
  - write and read pointers = 0, data_out = 0, empty_flag = 1, full_flag = 0.
  - Memory contents are not cleared.
- Pointers are ADDR_WIDTH+1 bits: low ADDR_WIDTH bits address memory, MSB is the wrap bit. Both wrap modulo 2**(ADDR_WIDTH+1).
- empty_flag = (wr_ptr == rd_ptr).
- full_flag = low bits equal AND MSBs differ.
- Both flags are derived combinationally from registered pointers, so they change in the cycle after the accepting edge.
- Write accepted when Wr_enable=1 and full_flag=0:
  - mem[wr_ptr low bits] <= data_in; wr_ptr increments.
- Read accepted when Read_enable=1 and empty_flag=0:
  - data_out <= mem[rd_ptr low bits]; rd_ptr increments.
  - Read latency: 1 cycle; data is valid after the accepting edge.
- data_out holds its last value when no read is accepted, including reads attempted while empty.
- Write while full: no state change; data is dropped.
- Read while empty: no state change; no fall-through of a same-cycle write.
- Simultaneous read and write:
  - Each side is accepted independently by its own rule, evaluated on pre-edge flags.
  - When neither flag is set, both proceed and occupancy is unchanged.
  - When full, only the read is accepted; when empty, only the write is accepted.
- Reset asserted mid-operation discards all stored entries; the next cycle is empty.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, adds outputs overflow_flag and underflow_flag (1 bit each, reset 0):
  - overflow_flag is sticky-set when Wr_enable=1 while full_flag=1.
  - underflow_flag is sticky-set when Read_enable=1 while empty_flag=1.
  - Both clear only on rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - a depth constant (2**ADDR_WIDTH);
  - pointer typedef (ADDR_WIDTH+1 bits);
  - data word typedef.
- One sub-module, sync_fifo_mem: simple dual-port RAM with synchronous write and a registered read port.
- Pointer and flag logic stays in sync_fifo.

Test Plan:
- Reset then Read_enable=1 for 1 cycle while empty -> empty_flag stays 1, data_out stays 0, pointers unchanged (underflow_flag=1 if FIFO_ERR_FLAGS_EN).
- Write 8, idle, write 9, then Read_enable for 3 cycles -> data_out 8 then 9; empty_flag=1 after second read; third read ignored, data_out holds 9.
- Write values 0..31 one every other cycle -> full_flag=1 after 32nd write; 33rd write value 99 ignored.
- Continuous read from full -> data_out sequence 0..31 in order; empty_flag=1 after last read.
- Simultaneous read+write with 5 entries held, for 40 cycles -> occupancy stays 5, output order preserved across pointer wrap.
- Assert rst with 10 entries held -> next cycle empty_flag=1, full_flag=0, data_out=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared constants and types for the single-clock FIFO.
//
//   Contents:
//     ADDR_WIDTH_DEF : default log2 of FIFO depth (5 -> 32 entries)
//     DATA_WIDTH_DEF : default data word width (8 bits)
//     DEPTH_DEF      : default number of entries, 2**ADDR_WIDTH_DEF
//     ptr_t          : read/write pointer, one wrap bit above the address bits
//     data_t         : one stored data word
//
//   Optional build macro used by the FIFO: FIFO_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;

  // The extra MSB separates "same slot, same lap" (empty) from
  // "same slot, one lap apart" (full).
  typedef logic [ADDR_WIDTH_DEF:0]   ptr_t;
  typedef logic [DATA_WIDTH_DEF-1:0] data_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//   Simple dual-port storage for sync_fifo: one synchronous write port and
//   one registered read port on the same clock.
//
//   Ports:
//     clk       : clock, all updates on the rising edge
//     rst       : synchronous active-high reset, clears the read register only
//     wr_en_i   : write strobe (already qualified by the FIFO's full check)
//     wr_addr_i : write address
//     wr_data_i : write data
//     rd_en_i   : read strobe (already qualified by the FIFO's empty check)
//     rd_addr_i : read address
//     rd_data_o : registered read data, holds when rd_en_i is low
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the storage array has no reset; a reset loop over every word
  // would stop it mapping onto RAM, and stale contents are unreachable
  // once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register does reset, so data_out is a known 0 after reset,
  // and it keeps its value whenever no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-in first-out buffer of 2**ADDR_WIDTH words of
//   DATA_WIDTH bits. Writes to a full FIFO and reads from an empty FIFO are
//   ignored. Read data is registered (one cycle latency).
//
//   Ports:
//     clk            : clock, all state updates on the rising edge
//     rst            : synchronous active-high reset, priority over all else
//     data_in        : write data
//     Wr_enable      : write request, accepted when not full
//     Read_enable    : read request, accepted when not empty
//     data_out       : registered read data, holds when no read is accepted
//     empty_flag     : FIFO holds 0 entries
//     full_flag      : FIFO holds 2**ADDR_WIDTH entries
//   With FIFO_ERR_FLAGS_EN defined, additionally:
//     overflow_flag  : sticky, set by a write request while full
//     underflow_flag : sticky, set by a read request while empty
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty_flag,
  output logic                  full_flag
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow_flag,
  output logic                  underflow_flag
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                wr_accept;
  logic                rd_accept;

  // Flags come straight from the registered pointers, so they reflect an
  // accepted access in the cycle after its edge.
  assign empty_flag = (wr_ptr_q == rd_ptr_q);
  assign full_flag  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                      (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Each side is judged on the pre-edge flags only: when full only the read
  // can go, when empty only the write can go (no fall-through).
  assign wr_accept = Wr_enable   & ~full_flag;
  assign rd_accept = Read_enable & ~empty_flag;

  // NOTE: next-state values get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Reads and writes never touch the same slot in one cycle: equal low
  // address bits mean either empty (read blocked) or full (write blocked).
  sync_fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (data_in),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (data_out)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error indications; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (Wr_enable && full_flag) begin
        overflow_q <= 1'b1;
      end
      if (Read_enable && empty_flag) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow_flag  = overflow_q;
  assign underflow_flag = underflow_q;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Self-checking bench for sync_fifo: a directed vector table, hand-written
//   multi-cycle sequences (fill, drain, streaming across pointer wrap, reset
//   while holding data) and a randomized phase checked against a queue model.
// -----------------------------------------------------------------------------
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  logic  clk = 1'b0;
  logic  rst;
  logic  wr;
  logic  rd;
  data_t din;
  data_t data_out;
  logic  empty_flag;
  logic  full_flag;
`ifdef FIFO_ERR_FLAGS_EN
  logic  overflow_flag;
  logic  underflow_flag;
`endif

  sync_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (din),
    .Wr_enable   (wr),
    .Read_enable (rd),
    .data_out    (data_out),
    .empty_flag  (empty_flag),
    .full_flag   (full_flag)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of stored words plus the last read word.
  data_t mq[$];
  data_t m_dout = '0;
  bit    m_ovf  = 1'b0;
  bit    m_unf  = 1'b0;

  typedef struct {
    bit    wr;
    bit    rd;
    data_t din;
    data_t exp_dout;
    bit    exp_empty;
    bit    exp_full;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // sample 1 time unit after the edge.
  task automatic step(input bit r, input bit w, input bit rq, input data_t d);
    bit m_full;
    bit m_empty;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    rst = r;
    wr  = w;
    rd  = rq;
    din = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (w && m_full)   m_ovf = 1'b1;
      if (rq && m_empty) m_unf = 1'b1;
      if (rq && !m_empty) m_dout = mq.pop_front();
      if (w && !m_full)   mq.push_back(d);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " dout"},  data_out,   m_dout);
    check({tag, " empty"}, empty_flag, mq.size() == 0);
    check({tag, " full"},  full_flag,  mq.size() == DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, " ovf"},   overflow_flag,  m_ovf);
    check({tag, " unf"},   underflow_flag, m_unf);
`endif
  endtask

  initial begin
    int p;
    data_t exp_v;

    rst = 1'b1;
    wr  = 1'b0;
    rd  = 1'b0;
    din = '0;
    #1;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("reset dout",  data_out,   32'h0);
    check("reset empty", empty_flag, 32'h1);
    check("reset full",  full_flag,  32'h0);
`ifdef FIFO_ERR_FLAGS_EN
    check("reset ovf", overflow_flag,  32'h0);
    check("reset unf", underflow_flag, 32'h0);
`endif

    // Read while empty, then write 8, idle, write 9, three reads.
    vecs[0] = '{wr:0, rd:1, din:8'h00, exp_dout:8'h00, exp_empty:1, exp_full:0};
    vecs[1] = '{wr:1, rd:0, din:8'h08, exp_dout:8'h00, exp_empty:0, exp_full:0};
    vecs[2] = '{wr:0, rd:0, din:8'h00, exp_dout:8'h00, exp_empty:0, exp_full:0};
    vecs[3] = '{wr:1, rd:0, din:8'h09, exp_dout:8'h00, exp_empty:0, exp_full:0};
    vecs[4] = '{wr:0, rd:1, din:8'h00, exp_dout:8'h08, exp_empty:0, exp_full:0};
    vecs[5] = '{wr:0, rd:1, din:8'h00, exp_dout:8'h09, exp_empty:1, exp_full:0};
    vecs[6] = '{wr:0, rd:1, din:8'h00, exp_dout:8'h09, exp_empty:1, exp_full:0};
    for (int i = 0; i < 7; i++) begin
      step(0, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d dout", i),  data_out,   vecs[i].exp_dout);
      check($sformatf("vec%0d empty", i), empty_flag, vecs[i].exp_empty);
      check($sformatf("vec%0d full", i),  full_flag,  vecs[i].exp_full);
`ifdef FIFO_ERR_FLAGS_EN
      check($sformatf("vec%0d unf", i), underflow_flag, 32'h1);
`endif
    end

    // Fill with 0..31, one write every other cycle; full only after the last.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 8'(i));
      check($sformatf("fill%0d full", i),  full_flag,  i == DEPTH - 1);
      check($sformatf("fill%0d empty", i), empty_flag, 32'h0);
      step(0, 0, 0, 8'h00);
    end
    step(0, 1, 0, 8'd99);
    check("overfill full", full_flag, 32'h1);
    check_model("overfill");

    // Continuous drain: 0..31 in order, empty after the last read.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 8'h00);
      check($sformatf("drain%0d dout", i),  data_out,   i);
      check($sformatf("drain%0d empty", i), empty_flag, i == DEPTH - 1);
      check($sformatf("drain%0d full", i),  full_flag,  32'h0);
    end

    // Stream with 5 entries held; order must survive the pointer wrap.
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'(100 + k));
    for (int c = 0; c < 40; c++) begin
      step(0, 1, 1, 8'(150 + c));
      exp_v = (c < 5) ? 8'(100 + c) : 8'(150 + c - 5);
      check($sformatf("stream%0d dout", c),  data_out,   exp_v);
      check($sformatf("stream%0d empty", c), empty_flag, 32'h0);
      check($sformatf("stream%0d full", c),  full_flag,  32'h0);
    end
    check("stream occupancy", 32'(mq.size()), 32'd5);

    // Reset while holding 10 entries.
    for (int k = 0; k < 5; k++) step(0, 1, 0, 8'(200 + k));
    check_model("pre-reset");
    step(1, 0, 0, 8'h00);
    check("midrst empty", empty_flag, 32'h1);
    check("midrst full",  full_flag,  32'h0);
    check("midrst dout",  data_out,   32'h0);
    step(0, 0, 1, 8'h00);
    check_model("post-reset read");

    // Randomized traffic, alternating write-heavy and read-heavy phases so
    // both full and empty are visited, with rare resets.
    for (int n = 0; n < 3000; n++) begin
      p = ((n / 250) % 2 == 1) ? 80 : 25;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < p,
           $urandom_range(0, 99) < (105 - p),
           8'($urandom));
      check_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo
